// File: rtl/uvma_debug_req_ctrl.sv
// Debug-request controller: raises debug_req_o for a command, waits for the core to
// enter and leave debug mode, and reports completion with a status code.
module uvma_debug_req_ctrl #(
    parameter int LEN_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [TMO_W-1:0] cmd_timeout,
    input  logic             abort_i,
    input  logic             debug_mode_i,
    output logic             debug_req_o,
    output logic             busy,
    output logic             done_pulse,
    output logic [1:0]       done_status,
    output logic [15:0]      ok_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_WAIT_EXIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STS_OK      = 2'b00,
        STS_TIMEOUT = 2'b01,
        STS_ALREADY = 2'b10,
        STS_ABORTED = 2'b11
    } status_t;

    state_t           state_q, state_d;
    status_t          status_q, status_d;
    logic [LEN_W-1:0] len_r;
    logic [TMO_W-1:0] tmo_r;
    logic [LEN_W-1:0] len_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [LEN_W-1:0] len_inc;
    logic [TMO_W-1:0] tmo_inc;
    logic [15:0]      ok_cnt;
    logic             accept;
    logic             len_hit;
    logic             tmo_hit;
    logic             ok_done;

    assign accept  = (state_q == ST_IDLE) && cmd_valid;
    assign len_inc = len_cnt + LEN_W'(1);
    assign tmo_inc = tmo_cnt + TMO_W'(1);

    // Hits compare the count including the current cycle, so ASSERT lasts exactly
    // cmd_len cycles and the timeout fires on the cmd_timeout-th counted cycle.
    assign len_hit = (len_r != '0) && (len_inc == len_r);
    assign tmo_hit = (tmo_r != '0) && (tmo_inc == tmo_r);
    assign ok_done = (state_q == ST_WAIT_EXIT) && (state_d == ST_DONE) && (status_d == STS_OK);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (debug_mode_i) begin
                        state_d  = ST_DONE;
                        status_d = STS_ALREADY;
                    end else begin
                        state_d = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (abort_i) begin
                    state_d  = ST_DONE;
                    status_d = STS_ABORTED;
                end else if (debug_mode_i) begin
                    state_d = ST_WAIT_EXIT;
                end else if (tmo_hit) begin
                    state_d  = ST_DONE;
                    status_d = STS_TIMEOUT;
                end else if (len_hit) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (abort_i) begin
                    state_d  = ST_DONE;
                    status_d = STS_ABORTED;
                end else if (debug_mode_i) begin
                    state_d = ST_WAIT_EXIT;
                end else if (tmo_hit) begin
                    state_d  = ST_DONE;
                    status_d = STS_TIMEOUT;
                end
            end
            ST_WAIT_EXIT: begin
                if (abort_i) begin
                    state_d  = ST_DONE;
                    status_d = STS_ABORTED;
                end else if (!debug_mode_i) begin
                    state_d  = ST_DONE;
                    status_d = STS_OK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            status_q <= STS_OK;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r   <= '0;
            tmo_r   <= '0;
            len_cnt <= '0;
            tmo_cnt <= '0;
        end else if (accept) begin
            len_r   <= cmd_len;
            tmo_r   <= cmd_timeout;
            len_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state_q == ST_ASSERT) begin
                len_cnt <= len_inc;
            end
            if ((state_q == ST_ASSERT) || (state_q == ST_WAIT_ACK)) begin
                tmo_cnt <= tmo_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_cnt <= '0;
        end else if (ok_done && (ok_cnt != '1)) begin
            ok_cnt <= ok_cnt + 16'd1;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign debug_req_o = (state_q == ST_ASSERT);
    assign done_pulse  = (state_q == ST_DONE);
    assign done_status = status_q;
    assign ok_count    = ok_cnt;

endmodule

// File: doc/uvma_debug_req_ctrl.md
UVMA_DEBUG_REQ_CTRL -- requirements
Module: uvma_debug_req_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of the debug_req pulse-length field.
REQ-002 Parameter TMO_W, default 16: width of the acknowledge-timeout field.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  request command offered.
REQ-006 cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 cmd_len  input  LEN_W  debug_req pulse length in cycles; 0 means hold until acknowledge.
REQ-008 cmd_timeout  input  TMO_W  maximum cycles to wait for acknowledge; 0 means no timeout.
REQ-009 abort_i  input  1  synchronous abort of the in-flight request.
REQ-010 debug_mode_i  input  1  core reports it is in debug mode (acknowledge).
REQ-011 debug_req_o  output  1  registered debug request to the core.
REQ-012 busy  output  1  controller is not in IDLE.
REQ-013 done_pulse  output  1  one-cycle completion strobe.
REQ-014 done_status  output  2  completion code: 00 OK, 01 TIMEOUT, 10 ALREADY, 11 ABORTED; valid only while done_pulse=1.
REQ-015 ok_count  output  16  number of OK completions; saturates at 16'hFFFF.

Function
REQ-016 The FSM SHALL have the states IDLE, ASSERT, WAIT_ACK, WAIT_EXIT and DONE; all outputs are registered or decoded from state only.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1, and cmd_len/cmd_timeout SHALL be latched on that cycle.
REQ-018 On acceptance with debug_mode_i=1, the FSM SHALL go to DONE with status ALREADY, and debug_req_o SHALL never assert.
REQ-019 On acceptance with debug_mode_i=0, the FSM SHALL go to ASSERT, and debug_req_o SHALL be 1 starting the cycle after acceptance (latency 1).
REQ-020 In ASSERT with cmd_len>0, debug_req_o SHALL stay high exactly cmd_len cycles, then the FSM SHALL go to WAIT_ACK with debug_req_o=0, unless acknowledged earlier.
REQ-021 In ASSERT with cmd_len=0, debug_req_o SHALL stay high until acknowledge, timeout or abort.
REQ-022 Acknowledge means debug_mode_i=1 sampled in ASSERT or WAIT_ACK; the FSM SHALL then go to WAIT_EXIT, with debug_req_o=0 from the next cycle.
REQ-023 The timeout counter SHALL clear on acceptance and increment every cycle in ASSERT or WAIT_ACK.
REQ-024 When cmd_timeout≠0 and the timeout count equals cmd_timeout without acknowledge, the FSM SHALL go to DONE with status TIMEOUT and debug_req_o=0.
REQ-025 WAIT_EXIT SHALL remain until debug_mode_i=0, then go to DONE with status OK; WAIT_EXIT has no timeout.
REQ-026 abort_i=1 in ASSERT, WAIT_ACK or WAIT_EXIT SHALL force DONE with status ABORTED and debug_req_o=0 next cycle; abort_i SHALL be ignored in IDLE and DONE.
REQ-027 Simultaneous-event priority SHALL be abort > acknowledge > timeout > pulse-length expiry.
REQ-028 DONE SHALL last exactly one cycle with done_pulse=1 and then return to IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-029 ok_count SHALL increment by 1 on each DONE with status OK, and SHALL hold at 16'hFFFF.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 While reset_n=0, regardless of clk: state=IDLE, debug_req_o=0, cmd_ready=1 (after reset release), busy=0, done_pulse=0, done_status=00, ok_count=0, all internal counters 0.
REQ-032 Reset asserted mid-request SHALL drop debug_req_o immediately, and SHALL produce no done_pulse.

Verification
REQ-033 cmd_len=4, cmd_timeout=0, debug_mode_i rises 10 cycles after acceptance and falls 5 cycles later -> debug_req_o high cycles 1-4; done_pulse with status OK; ok_count=1.
REQ-034 cmd_len=0, cmd_timeout=20, debug_mode_i stays 0 -> debug_req_o high 20 cycles, then done_pulse with status 01; ok_count unchanged.
REQ-035 debug_mode_i=1 at acceptance -> no debug_req_o; done_pulse one cycle after acceptance with status 10.
REQ-036 Acknowledge and timeout in the same cycle (cmd_timeout=3, debug_mode_i rises on the 3rd count) -> WAIT_EXIT entered, final status OK; abort_i in WAIT_EXIT -> status 11.
REQ-037 Reset pulsed while debug_req_o=1 -> debug_req_o=0 asynchronously, no done_pulse, ok_count=0; the next command runs normally.
REQ-038 ok_count preloaded to 16'hFFFE via 2 extra OK completions -> ok_count holds at 16'hFFFF.
